spi_pwm_reg_ctrl: RTL and testbench

- SPI (mode 0) peripheral that configures the PWM peripheral's five 8-bit control registers from an external host.
- Sits between the chip's dedicated input pins (SCLK, COPI, nCS) and pwm_peripheral.
- Owns, holds and drives en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle.
- Frame is 16 bits, MSB first: [15] R/W (1 = write), [14:8] address, [7:0] data.

---
 rtl/spi_pwm_reg_ctrl_if.sv | 11 +
 rtl/spi_pwm_reg_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_spi_pwm_reg_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pwm_reg_ctrl_if.sv
// SPI pin bundle between the external host and spi_pwm_reg_ctrl.
// The master modport is the host side and the slave modport is the register controller.
interface spi_pwm_reg_ctrl_if;
  logic sclk_in;
  logic copi_in;
  logic ncs_in;
  logic cipo_out;

  modport master (output sclk_in, output copi_in, output ncs_in, input cipo_out);
  modport slave  (input sclk_in, input copi_in, input ncs_in, output cipo_out);
endinterface

// File: rtl/spi_pwm_reg_ctrl.sv
// SPI mode-0 slave holding the five 8-bit PWM control registers.
// Frame: [15] R/W (1=write), [14:8] address, [7:0] data.
// Define SPI_READBACK_EN to return register contents on cipo_out during read frames.
//
// state  | meaning
// IDLE   | waiting for an ncs falling edge
// SHIFT  | capturing frame bits on SCLK rising edges
// COMMIT | one cycle that applies a valid write, then returns to IDLE
module spi_pwm_reg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_pwm_reg_ctrl_if.slave     spi,
  output logic [7:0]            en_reg_out_7_0,
  output logic [7:0]            en_reg_out_15_8,
  output logic [7:0]            en_reg_pwm_7_0,
  output logic [7:0]            en_reg_pwm_15_8,
  output logic [7:0]            pwm_duty_cycle,
  output logic                  txn_done,
  output logic                  txn_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [6:0] MAX_A   = 7'(MAX_ADDR);
  localparam logic [4:0] CNT_SAT = 5'd17;

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync, ncs_vld;
  logic sclk_d, ncs_d, ncs_armed;
  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_rise, ncs_fall;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign copi_s = copi_sync[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync[SYNC_STAGES-1];

  // ncs_vld tracks which ncs stages hold real samples, so the reset value of 1
  // cannot fake a falling edge when ncs is already low after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      ncs_vld   <= '0;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
      ncs_armed <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk_in};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi_in};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs_in};
      ncs_vld   <= {ncs_vld[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
      ncs_armed <= ncs_armed | (ncs_vld[SYNC_STAGES-1] & ncs_s);
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d & ncs_armed;

  logic [1:0]  state;
  logic [4:0]  bit_cnt, cnt_nxt;
  logic [15:0] shift_sr, sr_nxt;
  logic        nxt_addr_ok, cmt_addr_ok;

  // The bit on a coincident SCLK rising edge is folded in before the count check.
  always_comb begin
    cnt_nxt = bit_cnt;
    sr_nxt  = shift_sr;
    if (sclk_rise) begin
      sr_nxt = {shift_sr[14:0], copi_s};
      if (bit_cnt != CNT_SAT) cnt_nxt = bit_cnt + 5'd1;
    end
  end

  assign nxt_addr_ok = (sr_nxt[14:8] <= MAX_A);
  assign cmt_addr_ok = (shift_sr[14:8] <= MAX_A);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      shift_sr        <= '0;
      txn_done        <= 1'b0;
      txn_err         <= 1'b0;
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else begin
      txn_done <= 1'b0;
      txn_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            state    <= SHIFT;
            bit_cnt  <= '0;
            shift_sr <= '0;
          end
        end
        SHIFT: begin
          bit_cnt  <= cnt_nxt;
          shift_sr <= sr_nxt;
          if (ncs_rise) begin
            if (cnt_nxt == 5'd16) begin
              state <= COMMIT;
              if (sr_nxt[15] && !nxt_addr_ok) txn_err  <= 1'b1;
              else                            txn_done <= 1'b1;
            end else begin
              state   <= IDLE;
              txn_err <= 1'b1;
            end
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (shift_sr[15] && cmt_addr_ok) begin
            case (shift_sr[14:8])
              7'd0:    en_reg_out_7_0  <= shift_sr[7:0];
              7'd1:    en_reg_out_15_8 <= shift_sr[7:0];
              7'd2:    en_reg_pwm_7_0  <= shift_sr[7:0];
              7'd3:    en_reg_pwm_15_8 <= shift_sr[7:0];
              7'd4:    pwm_duty_cycle  <= shift_sr[7:0];
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [7:0] tx_sr, rd_val;
  logic       tx_active, cipo_q;

  assign sclk_fall = ~sclk_s & sclk_d;

  // After 8 bits sr_nxt[7:0] holds {R/W, address}.
  always_comb begin
    rd_val = 8'h00;
    if (sr_nxt[6:0] <= MAX_A) begin
      case (sr_nxt[6:0])
        7'd0:    rd_val = en_reg_out_7_0;
        7'd1:    rd_val = en_reg_out_15_8;
        7'd2:    rd_val = en_reg_pwm_7_0;
        7'd3:    rd_val = en_reg_pwm_15_8;
        7'd4:    rd_val = pwm_duty_cycle;
        default: rd_val = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != SHIFT || ncs_rise) begin
      tx_sr     <= 8'h00;
      tx_active <= 1'b0;
      cipo_q    <= 1'b0;
    end else if (sclk_rise && cnt_nxt == 5'd8 && !sr_nxt[7]) begin
      tx_sr     <= rd_val;
      tx_active <= 1'b1;
    end else if (sclk_fall && tx_active) begin
      cipo_q <= tx_sr[7];
      tx_sr  <= {tx_sr[6:0], 1'b0};
    end
  end

  assign spi.cipo_out = cipo_q;
`else
  assign spi.cipo_out = 1'b0;
`endif

endmodule

// File: tb/tb_spi_pwm_reg_ctrl.sv
// Directed bench for spi_pwm_reg_ctrl: a frame-level register model is checked
// against the DUT every cycle, plus literal expectations after each test step.
module tb_spi_pwm_reg_ctrl;
  localparam int SS   = 2;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_pwm_reg_ctrl_if spi_if ();

  logic [7:0] r0, r1, r2, r3, r4;
  logic       txn_done, txn_err;

  spi_pwm_reg_ctrl #(.SYNC_STAGES(SS), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .spi             (spi_if),
    .en_reg_out_7_0  (r0),
    .en_reg_out_15_8 (r1),
    .en_reg_pwm_7_0  (r2),
    .en_reg_pwm_15_8 (r3),
    .pwm_duty_cycle  (r4),
    .txn_done        (txn_done),
    .txn_err         (txn_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: outcome of the last frame and the cycle its pulse is due.
  logic [7:0] m_regs [5];
  int         pend_cyc  = -100;
  bit         pend_done = 1'b0;
  bit         pend_err  = 1'b0;
  bit         pend_wr   = 1'b0;
  int         pend_addr = 0;
  logic [7:0] pend_data = 8'h00;
  int         n_done = 0;
  int         n_err  = 0;
  int         ncs_hi = 0;

  always begin
    @(posedge clk);
    #2;
    if (rst) begin
      for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    end else begin
      if (cyc == pend_cyc + 1 && pend_wr) m_regs[pend_addr] = pend_data;
      chk("en_reg_out_7_0",  {24'h0, r0}, {24'h0, m_regs[0]});
      chk("en_reg_out_15_8", {24'h0, r1}, {24'h0, m_regs[1]});
      chk("en_reg_pwm_7_0",  {24'h0, r2}, {24'h0, m_regs[2]});
      chk("en_reg_pwm_15_8", {24'h0, r3}, {24'h0, m_regs[3]});
      chk("pwm_duty_cycle",  {24'h0, r4}, {24'h0, m_regs[4]});
      chk("txn_done", {31'h0, txn_done}, {31'h0, (cyc == pend_cyc) && pend_done});
      chk("txn_err",  {31'h0, txn_err},  {31'h0, (cyc == pend_cyc) && pend_err});
      if (txn_done) n_done++;
      if (txn_err)  n_err++;
      ncs_hi = spi_if.ncs_in ? ncs_hi + 1 : 0;
`ifdef SPI_READBACK_EN
      if (ncs_hi >= 6) chk("cipo_idle", {31'h0, spi_if.cipo_out}, 32'h0);
`else
      chk("cipo_tied", {31'h0, spi_if.cipo_out}, 32'h0);
`endif
    end
  end

  task automatic sclk_bit(input logic b, output logic cipo_s);
    spi_if.copi_in = b;
    repeat (HALF) @(negedge clk);
    cipo_s = spi_if.cipo_out;
    spi_if.sclk_in = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_if.sclk_in = 1'b0;
  endtask

  task automatic frame(input logic [31:0] val, input int nbits, output logic [7:0] rd);
    logic c;
    rd = 8'h00;
    @(negedge clk);
    spi_if.ncs_in = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= nbits; k++) begin
      sclk_bit(val[nbits-k], c);
      if (k >= 9 && k <= 16) rd[16-k] = c;
`ifdef SPI_READBACK_EN
      if (k <= 8) chk("cipo_bits_1_8", {31'h0, c}, 32'h0);
`endif
    end
    repeat (HALF) @(negedge clk);
    if (nbits != 16) begin
      pend_done = 1'b0; pend_err = 1'b1; pend_wr = 1'b0;
    end else if (val[15] && val[14:8] <= 7'd4) begin
      pend_done = 1'b1; pend_err = 1'b0; pend_wr = 1'b1;
    end else if (val[15]) begin
      pend_done = 1'b0; pend_err = 1'b1; pend_wr = 1'b0;
    end else begin
      pend_done = 1'b1; pend_err = 1'b0; pend_wr = 1'b0;
    end
    pend_addr = int'(val[14:8]);
    pend_data = val[7:0];
    // Pulse lands in the COMMIT cycle; the register follows one cycle later.
    pend_cyc = cyc + SS + 1;
    spi_if.ncs_in = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  logic [7:0] rd;
  logic       dummy;

  initial begin
    spi_if.sclk_in = 1'b0;
    spi_if.copi_in = 1'b0;
    spi_if.ncs_in  = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("reset_regs", {r0, r1, r2, r3}, 32'h0);
    chk("reset_duty", {24'h0, r4}, 32'h0);
    chk("reset_pulses", {30'h0, txn_done, txn_err}, 32'h0);
    chk("reset_cipo", {31'h0, spi_if.cipo_out}, 32'h0);

    frame(32'h80F0, 16, rd);
    chk("wr_out_7_0", {24'h0, r0}, 32'hF0);
    chk("wr_others", {r1, r2, r3, r4}, 32'h0);

    frame(32'h8480, 16, rd);
    chk("duty_80", {24'h0, r4}, 32'h80);
    frame(32'h8440, 16, rd);
    chk("duty_40", {24'h0, r4}, 32'h40);

    frame(32'h083A, 12, rd);
    frame(32'h1ABCD, 17, rd);
    frame(32'h8555, 16, rd);
    chk("err_regs_kept", {r0, r1, r2, r4}, 32'hF0000040);

    frame(32'h83A5, 16, rd);
    chk("wr_pwm_15_8", {24'h0, r3}, 32'hA5);
    frame(32'h0300, 16, rd);
`ifdef SPI_READBACK_EN
    chk("readback_addr3", {24'h0, rd}, 32'hA5);
`endif
    frame(32'h0000, 16, rd);
`ifdef SPI_READBACK_EN
    chk("readback_addr0", {24'h0, rd}, 32'hF0);
`endif
    frame(32'h0600, 16, rd);
`ifdef SPI_READBACK_EN
    chk("readback_bad_addr", {24'h0, rd}, 32'h00);
`endif

    // Reset after 8 bits of a write frame, with ncs held low across reset.
    @(negedge clk);
    spi_if.ncs_in = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 15; i >= 8; i--) sclk_bit(1'((32'h81CC >> i) & 1), dummy);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 7; i >= 0; i--) sclk_bit(1'((32'h81CC >> i) & 1), dummy);
    repeat (HALF) @(negedge clk);
    spi_if.ncs_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("midreset_regs", {r0, r1, r2, r3}, 32'h0);
    chk("midreset_duty", {24'h0, r4}, 32'h0);

    frame(32'h8233, 16, rd);
    chk("recover_pwm_7_0", {24'h0, r2}, 32'h33);

    chk("done_pulse_count", n_done, 8);
    chk("err_pulse_count", n_err, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
